// File: rtl/regfile_sb.sv
// Two-read, two-write integer register file with a pending-load scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [$clog2(NREGS)-1:0]   rs1_i,
    input  logic [$clog2(NREGS)-1:0]   rs2_i,
    output logic [XLEN-1:0]            rv1_o,
    output logic [XLEN-1:0]            rv2_o,
    output logic                       rs1_busy_o,
    output logic                       rs2_busy_o,
    input  logic                       we_i,
    input  logic [$clog2(NREGS)-1:0]   rd_i,
    input  logic [XLEN-1:0]            wdata_i,
    input  logic                       lwe_i,
    input  logic [$clog2(NREGS)-1:0]   lrd_i,
    input  logic [XLEN-1:0]            lwdata_i,
    input  logic                       iss_valid_i,
    input  logic [$clog2(NREGS)-1:0]   iss_rd_i,
    output logic [$clog2(NREGS):0]     busy_cnt_o,
    output logic                       waw_err_o
);

    localparam int unsigned AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             err_q, err_d;

    logic             a_wr, b_wr, iss_set;
    logic [NREGS-1:0] set_vec, clr_vec;
    logic             inc, dec;

    assign a_wr    = we_i && (rd_i != '0);
    assign b_wr    = lwe_i && (lrd_i != '0);
    assign iss_set = iss_valid_i && (iss_rd_i != '0);

    // Port B is applied last so it wins a same-register collision.
    always_comb begin
        regs_d = regs_q;
        if (a_wr) regs_d[rd_i] = wdata_i;
        if (b_wr) regs_d[lrd_i] = lwdata_i;
        regs_d[0] = '0;
    end

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (iss_set) set_vec[iss_rd_i] = 1'b1;
        if (b_wr)    clr_vec[lrd_i]    = 1'b1;
        busy_d    = (busy_q & ~clr_vec) | set_vec;
        busy_d[0] = 1'b0;
        inc   = iss_set && !busy_q[iss_rd_i];
        dec   = b_wr && busy_q[lrd_i] && !(iss_set && (iss_rd_i == lrd_i));
        cnt_d = cnt_q + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};
    end

    always_comb begin
        err_d = err_q;
        if (a_wr && busy_q[rd_i]) err_d = 1'b1;
        if (iss_set && busy_q[iss_rd_i] && !(b_wr && (lrd_i == iss_rd_i))) err_d = 1'b1;
        if (a_wr && b_wr && (rd_i == lrd_i)) err_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        rv1_o = regs_q[rs1_i];
        rv2_o = regs_q[rs2_i];
        if (a_wr && (rd_i == rs1_i))  rv1_o = wdata_i;
        if (a_wr && (rd_i == rs2_i))  rv2_o = wdata_i;
        if (b_wr && (lrd_i == rs1_i)) rv1_o = lwdata_i;
        if (b_wr && (lrd_i == rs2_i)) rv2_o = lwdata_i;
        if (rs1_i == '0) rv1_o = '0;
        if (rs2_i == '0) rv2_o = '0;
        rs1_busy_o = busy_q[rs1_i] && !(b_wr && (lrd_i == rs1_i));
        rs2_busy_o = busy_q[rs2_i] && !(b_wr && (lrd_i == rs2_i));
    end
`else
    always_comb begin
        rv1_o      = (rs1_i == '0) ? '0 : regs_q[rs1_i];
        rv2_o      = (rs2_i == '0) ? '0 : regs_q[rs2_i];
        rs1_busy_o = busy_q[rs1_i];
        rs2_busy_o = busy_q[rs2_i];
    end
`endif

    assign busy_cnt_o = cnt_q;
    assign waw_err_o  = err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised and directed bench for regfile_sb against an array-based reference model.
module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AW-1:0]   rs1, rs2, rd, lrd, iss_rd;
    logic [XLEN-1:0] rv1, rv2, wdata, lwdata;
    logic            rs1_busy, rs2_busy, we, lwe, iss_valid, waw_err;
    logic [AW:0]     busy_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [XLEN-1:0] m_reg  [NREGS];
    bit              m_busy [NREGS];
    bit              m_err;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .rs1_i       (rs1),
        .rs2_i       (rs2),
        .rv1_o       (rv1),
        .rv2_o       (rv2),
        .rs1_busy_o  (rs1_busy),
        .rs2_busy_o  (rs2_busy),
        .we_i        (we),
        .rd_i        (rd),
        .wdata_i     (wdata),
        .lwe_i       (lwe),
        .lrd_i       (lrd),
        .lwdata_i    (lwdata),
        .iss_valid_i (iss_valid),
        .iss_rd_i    (iss_rd),
        .busy_cnt_o  (busy_cnt),
        .waw_err_o   (waw_err)
    );

    // Reference model: architectural effect of one clock edge given current inputs.
    task automatic model_edge();
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                m_reg[i]  = '0;
                m_busy[i] = 0;
            end
            m_err = 0;
        end else begin
            if (we && rd != 0 && m_busy[rd]) m_err = 1;
            if (iss_valid && iss_rd != 0 && m_busy[iss_rd] && !(lwe && lrd == iss_rd)) m_err = 1;
            if (we && lwe && rd == lrd && rd != 0) m_err = 1;
            if (we && rd != 0) m_reg[rd] = wdata;
            if (lwe && lrd != 0) m_reg[lrd] = lwdata;
            if (lwe && lrd != 0) m_busy[lrd] = 0;
            if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1;
        end
    endtask

    function automatic logic [XLEN-1:0] exp_rv(logic [AW-1:0] a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (lwe && lrd == a) return lwdata;
        if (we && rd == a) return wdata;
`endif
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(logic [AW-1:0] a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (lwe && lrd == a) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    function automatic int exp_cnt();
        int c = 0;
        for (int i = 0; i < NREGS; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 0; lwe = 0; iss_valid = 0;
        rd = '0; lrd = '0; iss_rd = '0;
        wdata = '0; lwdata = '0;
    endtask

    task automatic test_reset();
        idle(); rst_n = 0; rs1 = '0; rs2 = '0;
        cycle(); cycle();
        rst_n = 1; we = 1; rd = 5; wdata = 32'hDEADBEEF;
        cycle();
        idle(); rs1 = 5; #1;
        n_cmp++;
        if (rv1 !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL reset_pre_write: got %h want deadbeef", rv1);
        end
        rst_n = 0;
        cycle();
        rst_n = 1; #1;
        n_cmp++;
        if (rv1 !== '0 || busy_cnt !== '0 || waw_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: rv1=%h cnt=%0d err=%b want 0/0/0", rv1, busy_cnt, waw_err);
        end
    endtask

    task automatic test_write_read();
        we = 1; rd = 7; wdata = 32'h12345678;
        cycle();
        idle(); rs2 = 7; #1;
        n_cmp++;
        if (rv2 !== 32'h12345678) begin
            n_fail++; $display("FAIL write_read: rv2=%h want 12345678", rv2);
        end
        we = 1; rd = 0; wdata = 32'hFFFFFFFF; rs1 = 0;
        cycle();
        idle(); rs1 = 0; #1;
        n_cmp++;
        if (rv1 !== '0 || waw_err !== 1'b0) begin
            n_fail++; $display("FAIL r0_write: rv1=%h err=%b want 0/0", rv1, waw_err);
        end
    endtask

    task automatic test_scoreboard();
        iss_valid = 1; iss_rd = 3;
        cycle();
        idle(); rs1 = 3; #1;
        n_cmp++;
        if (rs1_busy !== 1'b1 || busy_cnt !== 6'd1) begin
            n_fail++; $display("FAIL sb_set: busy=%b cnt=%0d want 1/1", rs1_busy, busy_cnt);
        end
        lwe = 1; lrd = 3; lwdata = 32'hA5;
        cycle();
        idle(); rs1 = 3; #1;
        n_cmp++;
        if (rs1_busy !== 1'b0 || busy_cnt !== 6'd0 || rv1 !== 32'hA5) begin
            n_fail++;
            $display("FAIL sb_clear: busy=%b cnt=%0d rv1=%h want 0/0/a5", rs1_busy, busy_cnt, rv1);
        end
        iss_valid = 1; iss_rd = 0;
        cycle();
        idle(); rs2 = 0; #1;
        n_cmp++;
        if (rs2_busy !== 1'b0 || busy_cnt !== 6'd0) begin
            n_fail++; $display("FAIL sb_r0: busy=%b cnt=%0d want 0/0", rs2_busy, busy_cnt);
        end
    endtask

    task automatic test_set_over_clear();
        iss_valid = 1; iss_rd = 9;
        cycle();
        idle(); lwe = 1; lrd = 9; lwdata = 32'h99; iss_valid = 1; iss_rd = 9;
        cycle();
        idle(); rs1 = 9; #1;
        n_cmp++;
        if (rs1_busy !== 1'b1 || busy_cnt !== 6'd1 || waw_err !== 1'b0) begin
            n_fail++;
            $display("FAIL set_over_clear: busy=%b cnt=%0d err=%b want 1/1/0",
                     rs1_busy, busy_cnt, waw_err);
        end
        lwe = 1; lrd = 9; lwdata = 32'h9A;
        cycle();
        idle();
    endtask

    task automatic test_collision();
        we = 1; rd = 4; wdata = 32'd1; lwe = 1; lrd = 4; lwdata = 32'd2;
        cycle();
        idle(); rs1 = 4; #1;
        n_cmp++;
        if (rv1 !== 32'd2 || waw_err !== 1'b1) begin
            n_fail++; $display("FAIL collision: rv1=%h err=%b want 2/1", rv1, waw_err);
        end
        cycle(); cycle(); cycle();
        n_cmp++;
        if (waw_err !== 1'b1) begin
            n_fail++; $display("FAIL err_sticky: err=%b want 1", waw_err);
        end
        rst_n = 0;
        cycle();
        rst_n = 1; #1;
        n_cmp++;
        if (waw_err !== 1'b0) begin
            n_fail++; $display("FAIL err_reset: err=%b want 0", waw_err);
        end
    endtask

    task automatic test_bypass();
        we = 1; rd = 6; wdata = 32'h11; iss_valid = 1; iss_rd = 6;
        cycle();
        idle(); lwe = 1; lrd = 6; lwdata = 32'h55; rs1 = 6; #1;
        n_cmp++;
`ifdef REGFILE_BYPASS_EN
        if (rv1 !== 32'h55 || rs1_busy !== 1'b0) begin
            n_fail++; $display("FAIL bypass_same: rv1=%h busy=%b want 55/0", rv1, rs1_busy);
        end
`else
        if (rv1 !== 32'h11 || rs1_busy !== 1'b1) begin
            n_fail++; $display("FAIL bypass_same: rv1=%h busy=%b want 11/1", rv1, rs1_busy);
        end
`endif
        cycle();
        idle(); rs1 = 6; #1;
        n_cmp++;
        if (rv1 !== 32'h55 || rs1_busy !== 1'b0 || waw_err !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_next: rv1=%h busy=%b err=%b want 55/0/0", rv1, rs1_busy, waw_err);
        end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int it = 0; it < 600; it++) begin
            rst_n     = ($urandom_range(0, 60) != 0);
            // Narrow address range on most cycles to provoke hazards.
            we        = $urandom_range(0, 1);
            lwe       = $urandom_range(0, 2) == 0;
            iss_valid = $urandom_range(0, 2) == 0;
            if ($urandom_range(0, 3) != 0) begin
                rd = AW'($urandom_range(0, 7)); lrd = AW'($urandom_range(0, 7));
                iss_rd = AW'($urandom_range(0, 7));
                rs1 = AW'($urandom_range(0, 7)); rs2 = AW'($urandom_range(0, 7));
            end else begin
                rd = AW'($urandom); lrd = AW'($urandom); iss_rd = AW'($urandom);
                rs1 = AW'($urandom); rs2 = AW'($urandom);
            end
            wdata = $urandom; lwdata = $urandom;
            #1;
            n_cmp++;
            if (rv1 !== exp_rv(rs1) || rv2 !== exp_rv(rs2) ||
                rs1_busy !== exp_busy(rs1) || rs2_busy !== exp_busy(rs2) ||
                busy_cnt !== (AW+1)'(exp_cnt()) || waw_err !== m_err) begin
                n_fail++;
                if (errs++ < 10)
                    $display("FAIL random[%0d]: rv1=%h/%h rv2=%h/%h b1=%b/%b b2=%b/%b cnt=%0d/%0d err=%b/%b",
                             it, rv1, exp_rv(rs1), rv2, exp_rv(rs2), rs1_busy, exp_busy(rs1),
                             rs2_busy, exp_busy(rs2), busy_cnt, exp_cnt(), waw_err, m_err);
            end
            cycle();
        end
        idle(); rst_n = 1;
    endtask

    initial begin
        for (int i = 0; i < NREGS; i++) begin
            m_reg[i] = '0; m_busy[i] = 0;
        end
        m_err = 0;
        test_reset();
        test_write_read();
        test_scoreboard();
        test_set_over_clear();
        test_collision();
        test_bypass();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with two combinational read ports, two write-back ports and a per-register pending-load scoreboard. It serves the single-cycle/multicycle CPU datapath, with ALU results on port A and returning load data on port B. The scoreboard tracks registers whose load data has not yet returned and raises busy flags so decode can stall. Address generation stays in the datapath; this block only stores and tracks state.

## Interface
- XLEN, 32: register width in bits.
- NREGS, 32: number of registers; power of two, at least 2.
- AW, $clog2(NREGS): register-address width; derived, not overridden.

- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  synchronous, active-low reset.
- rs1, rs2  in  AW  read addresses.
- rv1, rv2  out  XLEN  read data; combinational.
- rs1_busy, rs2_busy  out  1  addressed register has a pending load; combinational.
- we  in  1  port A (ALU) write enable.
- rd  in  AW  port A write address.
- wdata  in  XLEN  port A write data.
- lwe  in  1  port B (load return) write enable.
- lrd  in  AW  port B write address.
- lwdata  in  XLEN  port B write data.
- iss_valid  in  1  a load to iss_rd is issued this cycle.
- iss_rd  in  AW  destination of the issued load.
- busy_cnt  out  AW+1  number of registers currently marked busy.
- waw_err  out  1  sticky protocol-error flag.

## Operation
- Register 0 reads as 0 at all times. Writes to register 0 are discarded. Register 0 is never marked busy.
- Writes:
  - At posedge, `we` writes `wdata` to `rd`, and `lwe` writes `lwdata` to `lrd`.
  - If both ports target the same nonzero register, port B wins and waw_err sets.
- Scoreboard, one bit per register:
  - `iss_valid` with `iss_rd`≠0 sets busy[iss_rd].
  - `lwe` with `lrd`≠0 clears busy[lrd].
  - Set and clear of the same register in the same cycle: set wins, because a new load is issued as the old one returns.
- waw_err sets, and stays set until reset, on any of:
  - a port A write to a busy register;
  - `iss_valid` to an already-busy register, with no same-cycle clear;
  - a port A/B collision as above.
  - The offending write or issue is still performed.
- A port B write to a non-busy register writes data and leaves the scoreboard unchanged. This is not an error.
- busy_cnt always equals the popcount of the busy bits:
  - +1 on set of a clear bit;
  - −1 on clear of a set bit;
  - net 0 when both happen to different registers, or set-over-clear on the same register.
  - Never wraps; the maximum is NREGS−1.

## Timing
- Read latency 0: `rv`/`busy` follow `rs1`/`rs2` combinationally.
- Write latency 1: data is visible on reads in the cycle after the write edge, unless bypass is enabled (see Configuration).
- Busy set/clear takes effect at the next posedge.
- Reset values, with rst_n low at a posedge:
  - all registers 0;
  - all busy bits 0, busy_cnt 0, waw_err 0.
  - rv1/rv2 read 0 and rs*_busy read 0 from the following cycle.
- Reset overrides any same-cycle we/lwe/iss_valid. Pending loads are forgotten, and a load returning after reset writes data without scoreboard effect.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read whose address matches a same-cycle nonzero write returns the write data combinationally; port B takes priority over port A.
  - rsN_busy is forced low when lwe/lrd matches rsN in the same cycle.
- Undefined:
  - Reads return stored contents only; same-cycle writes are visible next cycle.
  - Busy reflects the registered bits only.

## Test plan
- Reset then read: rst_n=0 for 1 cycle after writing 0xDEADBEEF to r5 -> rv1(rs1=5)=0, busy_cnt=0, waw_err=0.
- Write/read and r0: we, rd=7, wdata=0x12345678 -> next cycle rv2(rs2=7)=0x12345678. Write rd=0 with 0xFFFFFFFF -> rv1(rs1=0)=0.
- Scoreboard: iss_valid, iss_rd=3 -> next cycle rs1_busy=1, busy_cnt=1. Then lwe, lrd=3, lwdata=0xA5 -> next cycle rs1_busy=0, busy_cnt=0, rv1=0xA5.
- Set-over-clear: r9 busy; same cycle lwe lrd=9 and iss_valid iss_rd=9 -> r9 still busy, busy_cnt unchanged, waw_err=0.
- Collision: we rd=4 wdata=1 and lwe lrd=4 lwdata=2 in the same cycle -> r4=2, waw_err=1 and it stays 1 until rst_n.
- Bypass: with REGFILE_BYPASS_EN, lwe lrd=6 lwdata=0x55 and rs1=6 -> rv1=0x55 and rs1_busy=0 in the same cycle. Without the macro, rv1 holds the old value until the next cycle.
